// File: rtl/acc_readout_ctrl_pkg.sv
// Shared accelerator definitions for the accumulator readout path:
// width helpers and the readout controller state encoding.
package acc_readout_ctrl_pkg;

  typedef enum logic [1:0] {
    RDO_IDLE  = 2'd0,
    RDO_READ  = 2'd1,
    RDO_DRAIN = 2'd2
  } rdo_state_t;

  function automatic int psum_width(input int weight_w, input int act_w, input int cols);
    return weight_w + act_w + $clog2(cols);
  endfunction

  // A single-row memory still needs a one-bit address port.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/acc_readout_fifo.sv
// Two-entry shift FIFO; the head always sits in slot 0 so the output is a
// plain register and stays stable while the consumer stalls.
module acc_readout_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] slot0_r, slot1_r, slot0_nx, slot1_nx;
  logic             v0_r, v1_r, v0_nx, v1_nx;

  // Next-state of the two slots for each push/pop combination.
  always_comb begin
    slot0_nx = slot0_r;
    slot1_nx = slot1_r;
    v0_nx    = v0_r;
    v1_nx    = v1_r;
    case ({push, pop})
      2'b10: begin
        if (!v0_r) begin
          slot0_nx = push_data;
          v0_nx    = 1'b1;
        end else begin
          slot1_nx = push_data;
          v1_nx    = 1'b1;
        end
      end
      2'b01: begin
        slot0_nx = slot1_r;
        v0_nx    = v1_r;
        v1_nx    = 1'b0;
      end
      2'b11: begin
        if (v1_r) begin
          slot0_nx = slot1_r;
          slot1_nx = push_data;
        end else begin
          slot0_nx = push_data;
        end
      end
      default: begin
        slot0_nx = slot0_r;
      end
    endcase
  end

  // Slot storage and occupancy flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_r <= '0;
      slot1_r <= '0;
      v0_r    <= 1'b0;
      v1_r    <= 1'b0;
    end else begin
      slot0_r <= slot0_nx;
      slot1_r <= slot1_nx;
      v0_r    <= v0_nx;
      v1_r    <= v1_nx;
    end
  end

  assign head_data  = slot0_r;
  assign head_valid = v0_r;
  assign count      = {1'b0, v0_r} + {1'b0, v1_r};

endmodule

// File: rtl/acc_readout_ctrl.sv
// Accumulator readout controller: streams rows from the accumulator memory
// to a ready/valid consumer and flags columns that disagree with column 0.
module acc_readout_ctrl
  import acc_readout_ctrl_pkg::*;
#(
  parameter int SYSTOLIC_SIZE     = 8,
  parameter int WEIGHT_WIDTH      = 8,
  parameter int ACTIVATION_WIDTH  = 8,
  parameter int PARTIAL_SUM_WIDTH = psum_width(WEIGHT_WIDTH, ACTIVATION_WIDTH, SYSTOLIC_SIZE),
  parameter int PATTERN_NUMBER    = 1,
  parameter int ADDR_WIDTH        = addr_width(PATTERN_NUMBER * SYSTOLIC_SIZE)
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  input  logic [ADDR_WIDTH-1:0]                      base_addr,
  input  logic [ADDR_WIDTH:0]                        num_rows,
  input  logic                                       test_mode,
  output logic [ADDR_WIDTH-1:0]                      rd_addr,
  input  logic [PARTIAL_SUM_WIDTH*SYSTOLIC_SIZE-1:0] rd_data_flat,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [PARTIAL_SUM_WIDTH*SYSTOLIC_SIZE-1:0] out_data_flat,
  output logic                                       out_last,
  output logic                                       busy,
  output logic                                       done,
  output logic [SYSTOLIC_SIZE-1:0]                   fault_map
);

  localparam int DEPTH = PATTERN_NUMBER * SYSTOLIC_SIZE;
  localparam int DW    = PARTIAL_SUM_WIDTH * SYSTOLIC_SIZE;
  localparam int RW    = ADDR_WIDTH + 1;
  localparam logic [RW-1:0]         DEPTH_C     = RW'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR_C = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [RW-1:0]         ONE_ROW_C   = RW'(1);

  rdo_state_t state_r, state_nx;

  logic [ADDR_WIDTH-1:0]    rd_addr_r;
  logic [RW-1:0]            rows_left_r;
  logic [RW-1:0]            nrows_clamp_s;
  logic                     inflight_r, inflight_last_r;
  logic                     busy_r, done_r;
  logic [SYSTOLIC_SIZE-1:0] fault_map_r, mismatch_s;
  logic                     start_ok_s, pop_s, issue_s, last_issue_s, last_hs_s;
  logic [2:0]               occ_s;
  logic [DW:0]              head_data_s;
  logic                     head_valid_s;
  logic [1:0]               fifo_count_s;

  assign start_ok_s    = start && (state_r == RDO_IDLE);
  assign nrows_clamp_s = (num_rows > DEPTH_C) ? DEPTH_C : num_rows;
  assign pop_s         = head_valid_s && out_ready;
  // Rows already buffered or on their way back must fit the two FIFO slots.
  assign occ_s         = {1'b0, fifo_count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
  assign issue_s       = (state_r == RDO_READ) && (rows_left_r != '0) && (occ_s < 3'd2);
  assign last_issue_s  = issue_s && (rows_left_r == ONE_ROW_C);
  assign last_hs_s     = pop_s && head_data_s[DW];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RDO_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      RDO_IDLE: begin
        if (start_ok_s && (nrows_clamp_s != '0)) begin
          state_nx = RDO_READ;
        end else begin
          state_nx = RDO_IDLE;
        end
      end
      RDO_READ: begin
        if (last_issue_s) begin
          state_nx = RDO_DRAIN;
        end else begin
          state_nx = RDO_READ;
        end
      end
      RDO_DRAIN: begin
        if (last_hs_s) begin
          state_nx = RDO_IDLE;
        end else begin
          state_nx = RDO_DRAIN;
        end
      end
      default: state_nx = RDO_IDLE;
    endcase
  end

  // Address counter, remaining-row count and in-flight read tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_r       <= '0;
      rows_left_r     <= '0;
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
    end else begin
      if (start_ok_s) begin
        rd_addr_r   <= base_addr;
        rows_left_r <= nrows_clamp_s;
      end else if (issue_s) begin
        rd_addr_r   <= (rd_addr_r == LAST_ADDR_C) ? '0 : rd_addr_r + ADDR_WIDTH'(1);
        rows_left_r <= rows_left_r - ONE_ROW_C;
      end
      inflight_r      <= issue_s;
      inflight_last_r <= last_issue_s;
    end
  end

  // Column-consistency compare of the row being captured.
  always_comb begin
    mismatch_s = '0;
    for (int i = 1; i < SYSTOLIC_SIZE; i++) begin
      mismatch_s[i] = (rd_data_flat[i*PARTIAL_SUM_WIDTH +: PARTIAL_SUM_WIDTH]
                       != rd_data_flat[PARTIAL_SUM_WIDTH-1:0]);
    end
  end

  // Status flags: busy, done pulse and sticky fault map.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      fault_map_r <= '0;
    end else begin
      done_r <= (start_ok_s && (nrows_clamp_s == '0)) || last_hs_s;
      if (start_ok_s) begin
        busy_r      <= (nrows_clamp_s != '0);
        fault_map_r <= '0;
      end else begin
        if (last_hs_s) begin
          busy_r <= 1'b0;
        end
        if (inflight_r && test_mode) begin
          fault_map_r <= fault_map_r | mismatch_s;
        end
      end
    end
  end

  acc_readout_fifo #(
    .WIDTH(DW + 1)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_r),
    .push_data ({inflight_last_r, rd_data_flat}),
    .pop       (pop_s),
    .head_data (head_data_s),
    .head_valid(head_valid_s),
    .count     (fifo_count_s)
  );

  assign rd_addr       = rd_addr_r;
  assign out_valid     = head_valid_s;
  assign out_data_flat = head_data_s[DW-1:0];
  assign out_last      = head_valid_s && head_data_s[DW];
  assign busy          = busy_r;
  assign done          = done_r;
  assign fault_map     = fault_map_r;

endmodule

// File: tb/tb_acc_readout_ctrl.sv
// Directed bench for acc_readout_ctrl with a one-cycle-latency accumulator
// memory model whose row r holds r+1 in every column.
module tb_acc_readout_ctrl;

  localparam int S   = 8;
  localparam int PSW = 19;
  localparam int DW  = PSW * S;
  localparam int AW  = 3;

  logic          clk, rst_n, start, test_mode, out_valid, out_ready, out_last, busy, done;
  logic [AW-1:0] base_addr, rd_addr;
  logic [AW:0]   num_rows;
  logic [DW-1:0] rd_data_flat, out_data_flat;
  logic [S-1:0]  fault_map;

  int   vec_cnt = 0;
  int   err_cnt = 0;
  bit   fault_en = 1'b0;
  logic [15:0] pat = 16'b1001_0110_1100_1001;

  acc_readout_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .base_addr    (base_addr),
    .num_rows     (num_rows),
    .test_mode    (test_mode),
    .rd_addr      (rd_addr),
    .rd_data_flat (rd_data_flat),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data_flat(out_data_flat),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done),
    .fault_map    (fault_map)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row r = r+1 per column; optional corruption of column 5 on row 3.
  function automatic logic [DW-1:0] row_val(input int r);
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < S; i++) begin
      v[i*PSW +: PSW] = PSW'(r + 1);
      if (fault_en && r == 3 && i == 5) v[i*PSW +: PSW] = PSW'((r + 1) ^ 1);
    end
    return v;
  endfunction

  always @(posedge clk) rd_data_flat <= row_val(int'(rd_addr));

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] want);
    vec_cnt++;
    if (got !== want) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_data"}, out_data_flat, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_fault"}, fault_map, 0);
    check({tag, "_addr"}, rd_addr, 0);
  endtask

  // One readout: start is driven now (a negedge), returns at a later negedge.
  task automatic run_readout(input logic [2:0] base, input logic [3:0] nrows, input int exp_n,
                             input bit stall, input int abort_at);
    int k = 0;
    int c = 1;
    int first_c = -1;
    int done_c = -1;
    bit was_stall = 1'b0;
    logic [DW-1:0] held = '0;
    start = 1'b1; base_addr = base; num_rows = nrows; out_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; base_addr = ~base; num_rows = 4'd1;
    @(negedge clk);
    check("busy_c1", busy, exp_n > 0);
    check("fault_clr", fault_map, 0);
    if (exp_n > 0) check("rd_addr_c1", rd_addr, base);
    while (done_c < 0 && c < 60) begin
      if (was_stall) check("stall_hold", out_data_flat, held);
      if (out_valid && first_c < 0) first_c = c;
      if (out_valid && out_ready) begin
        check("row_data", out_data_flat, row_val((int'(base) + k) % 8));
        check("row_last", out_last, k == exp_n - 1);
        k++;
        if (k == abort_at) begin
          rst_n = 1'b0;
          #1;
          check_reset_outputs("abort");
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end
      end
      if (done) begin
        done_c = c;
        check("busy_at_done", busy, 0);
      end
      was_stall = out_valid && !out_ready;
      held = out_data_flat;
      @(posedge clk);
      #1;
      out_ready = stall ? pat[c % 16] : 1'b1;
      start = (c == 2);
      c++;
      @(negedge clk);
    end
    start = 1'b0;
    check("done_seen", done_c >= 0, 1);
    check("row_count", k, exp_n);
    if (exp_n > 0) check("first_valid_cycle", first_c, 3);
    else check("no_valid", first_c < 0, 1);
    if (!stall) check("done_cycle", done_c, (exp_n > 0) ? 3 + exp_n : 1);
    @(negedge clk);
    check("done_pulse", done, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; num_rows = '0;
    test_mode = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    run_readout(3'd0, 4'd8, 8, 1'b0, -1);
    check("fault_none", fault_map, 0);
    run_readout(3'd6, 4'd4, 4, 1'b0, -1);
    run_readout(3'd0, 4'd8, 8, 1'b1, -1);
    test_mode = 1'b1; fault_en = 1'b1;
    run_readout(3'd0, 4'd8, 8, 1'b0, -1);
    check("fault_map", fault_map, 8'h20);
    repeat (2) @(negedge clk);
    check("fault_hold", fault_map, 8'h20);
    test_mode = 1'b0; fault_en = 1'b0;
    run_readout(3'd0, 4'd0, 0, 1'b0, -1);
    run_readout(3'd0, 4'd12, 8, 1'b0, -1);
    test_mode = 1'b1; fault_en = 1'b1;
    run_readout(3'd2, 4'd8, 8, 1'b0, 3);
    test_mode = 1'b0; fault_en = 1'b0;
    run_readout(3'd5, 4'd8, 8, 1'b1, -1);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
